// File: rtl/gpio_ext.sv
// rtl/gpio_ext.sv - parametrised GPIO with input debounce, edge interrupts and a TL-UL register port
// Defining GPIO_EXT_MASKED_WRITE_EN adds the MASKED_OUT_LOWER/UPPER registers.

package tlul_pkg;
   localparam logic [2:0] PutFullData    = 3'h0;
   localparam logic [2:0] PutPartialData = 3'h1;
   localparam logic [2:0] Get            = 3'h4;
   localparam logic [2:0] AccessAck      = 3'h0;
   localparam logic [2:0] AccessAckData  = 3'h1;

   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic       rsp_intg;
      logic [3:0] data_intg;
   } tl_d_user_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic [31:0] d_data;
      tl_d_user_t  d_user;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;
endpackage

// Parity-based response integrity: one bit over the response header, one per data byte.
module tlul_rsp_intg_gen (
   input  tlul_pkg::tl_d2h_t tl_i,
   output tlul_pkg::tl_d2h_t tl_o
);
   always_comb begin
      tl_o = tl_i;
      tl_o.d_user.rsp_intg = ^{tl_i.d_opcode, tl_i.d_size, tl_i.d_source, tl_i.d_error};
      for (int b = 0; b < 4; b++) tl_o.d_user.data_intg[b] = ^tl_i.d_data[8*b +: 8];
   end
endmodule

module gpio_ext #(
   parameter int NumGpio    = 32,
   parameter int SyncStages = 2,
   parameter int DbncCntW   = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  tlul_pkg::tl_h2d_t  tl_i,
   output tlul_pkg::tl_d2h_t  tl_o,
   input  logic [NumGpio-1:0] cio_gpio_i,
   output logic [NumGpio-1:0] cio_gpio_o,
   output logic [NumGpio-1:0] cio_gpio_en_o,
   output logic [NumGpio-1:0] intr_gpio_o,
   output logic               intr_o
);
   import tlul_pkg::*;

   localparam logic [3:0] RegDataIn     = 4'h0;
   localparam logic [3:0] RegDataOut    = 4'h1;
   localparam logic [3:0] RegDirOe      = 4'h2;
   localparam logic [3:0] RegIntrState  = 4'h3;
   localparam logic [3:0] RegIntrEnable = 4'h4;
   localparam logic [3:0] RegRiseEn     = 4'h5;
   localparam logic [3:0] RegFallEn     = 4'h6;
   localparam logic [3:0] RegDbncLimit  = 4'h7;
   localparam logic [3:0] RegIntrTest   = 4'h8;
`ifdef GPIO_EXT_MASKED_WRITE_EN
   localparam logic [3:0] RegMaskLower  = 4'h9;
   localparam logic [3:0] RegMaskUpper  = 4'hA;
`endif

   logic [NumGpio-1:0]  data_out, data_out_d, dir_oe, intr_state, intr_enable, rise_en, fall_en;
   logic [NumGpio-1:0]  stable, sync, upd, rise, fall, w1c, tset, wdata_n;
   logic [NumGpio-1:0]  sync_q [SyncStages];
   logic [DbncCntW-1:0] cnt [NumGpio];
   logic [DbncCntW-1:0] dbnc_limit, lim_m1;

   logic        d_valid, d_error;
   logic [2:0]  d_opcode;
   logic [1:0]  d_size;
   logic [7:0]  d_source;
   logic [31:0] d_data, rdata;
   logic [3:0]  offset;
   logic        accept, mapped, is_get, is_put, bad, wr, dbnc_wr;
   logic        unused_tl;

   assign offset  = tl_i.a_address[5:2];
   assign accept  = tl_i.a_valid && !d_valid;
   assign is_get  = (tl_i.a_opcode == Get);
   assign is_put  = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
   assign wdata_n = tl_i.a_data[NumGpio-1:0];
   assign unused_tl = ^{tl_i.a_address[31:6], tl_i.a_address[1:0], tl_i.a_data};

   always_comb begin
      mapped = (offset <= RegIntrTest);
`ifdef GPIO_EXT_MASKED_WRITE_EN
      if (offset == RegMaskLower || offset == RegMaskUpper) mapped = 1'b1;
`endif
   end

   assign bad = !mapped || (tl_i.a_size != 2'd2) || !(is_get || is_put) ||
                ((tl_i.a_opcode == PutPartialData) && (tl_i.a_mask != 4'hF));
   assign wr      = accept && is_put && !bad;
   assign dbnc_wr = wr && (offset == RegDbncLimit);
   assign w1c     = (wr && offset == RegIntrState) ? wdata_n : '0;
   assign tset    = (wr && offset == RegIntrTest)  ? wdata_n : '0;

   // Masked writes only touch DATA_OUT bits whose mask half is set.
   always_comb begin
      data_out_d = data_out;
      if (wr && offset == RegDataOut) data_out_d = wdata_n;
`ifdef GPIO_EXT_MASKED_WRITE_EN
      if (wr && offset == RegMaskLower) begin
         for (int i = 0; i < NumGpio && i < 16; i++)
            if (tl_i.a_data[16+i]) data_out_d[i] = tl_i.a_data[i];
      end
      if (wr && offset == RegMaskUpper) begin
         for (int i = 16; i < NumGpio; i++)
            if (tl_i.a_data[i]) data_out_d[i] = tl_i.a_data[i-16];
      end
`endif
   end

   always_comb begin
      rdata = '0;
      case (offset)
         RegDataIn:     rdata = 32'(stable);
         RegDataOut:    rdata = 32'(data_out);
         RegDirOe:      rdata = 32'(dir_oe);
         RegIntrState:  rdata = 32'(intr_state);
         RegIntrEnable: rdata = 32'(intr_enable);
         RegRiseEn:     rdata = 32'(rise_en);
         RegFallEn:     rdata = 32'(fall_en);
         RegDbncLimit:  rdata = 32'(dbnc_limit);
         default:       rdata = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         d_valid  <= 1'b0;
         d_error  <= 1'b0;
         d_opcode <= '0;
         d_size   <= '0;
         d_source <= '0;
         d_data   <= '0;
      end else if (accept) begin
         d_valid  <= 1'b1;
         d_error  <= bad;
         d_opcode <= is_get ? AccessAckData : AccessAck;
         d_size   <= tl_i.a_size;
         d_source <= tl_i.a_source;
         d_data   <= (bad || !is_get) ? '0 : rdata;
      end else if (d_valid && tl_i.d_ready) begin
         d_valid  <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_out    <= '0;
         dir_oe      <= '0;
         intr_enable <= '0;
         rise_en     <= '0;
         fall_en     <= '0;
         dbnc_limit  <= '0;
         intr_state  <= '0;
      end else begin
         data_out <= data_out_d;
         if (wr && offset == RegDirOe)      dir_oe      <= wdata_n;
         if (wr && offset == RegIntrEnable) intr_enable <= wdata_n;
         if (wr && offset == RegRiseEn)     rise_en     <= wdata_n;
         if (wr && offset == RegFallEn)     fall_en     <= wdata_n;
         if (dbnc_wr)                       dbnc_limit  <= tl_i.a_data[DbncCntW-1:0];
         // Hardware and test sets are ORed in after the W1C so they win on collision.
         intr_state <= (intr_state & ~w1c) | (rise & rise_en) | (fall & fall_en) | tset;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int s = 0; s < SyncStages; s++) sync_q[s] <= '0;
      end else begin
         sync_q[0] <= cio_gpio_i;
         for (int s = 1; s < SyncStages; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   assign sync   = sync_q[SyncStages-1];
   assign lim_m1 = (dbnc_limit == '0) ? '0 : dbnc_limit - DbncCntW'(1);

   always_comb begin
      upd = '0;
      for (int i = 0; i < NumGpio; i++)
         upd[i] = (sync[i] != stable[i]) && (cnt[i] == lim_m1) && !dbnc_wr;
   end

   assign rise = upd & sync;
   assign fall = upd & ~sync;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stable <= '0;
         for (int i = 0; i < NumGpio; i++) cnt[i] <= '0;
      end else begin
         stable <= stable ^ upd;
         for (int i = 0; i < NumGpio; i++) begin
            if (dbnc_wr || upd[i] || (sync[i] == stable[i])) cnt[i] <= '0;
            else                                             cnt[i] <= cnt[i] + DbncCntW'(1);
         end
      end
   end

   assign cio_gpio_o    = data_out;
   assign cio_gpio_en_o = dir_oe;
   assign intr_gpio_o   = intr_state & intr_enable;
   assign intr_o        = |intr_gpio_o;

   tl_d2h_t rsp;
   always_comb begin
      rsp          = '0;
      rsp.d_valid  = d_valid;
      rsp.d_opcode = d_opcode;
      rsp.d_size   = d_size;
      rsp.d_source = d_source;
      rsp.d_data   = d_data;
      rsp.d_error  = d_error;
      rsp.a_ready  = !d_valid;
   end

   tlul_rsp_intg_gen u_rsp_intg (
      .tl_i (rsp),
      .tl_o (tl_o)
   );
endmodule

// File: tb/tb_gpio_ext.sv
// tb/tb_gpio_ext.sv - self-checking bench for gpio_ext against a pin-history reference model
module tb_gpio_ext;
   import tlul_pkg::*;
   localparam int SS = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   tl_h2d_t     tl_i;
   tl_d2h_t     tl_o;
   logic [31:0] pins, gpo, gpo_en, intr_gpio;
   logic        intr;

   gpio_ext dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .tl_i          (tl_i),
      .tl_o          (tl_o),
      .cio_gpio_i    (pins),
      .cio_gpio_o    (gpo),
      .cio_gpio_en_o (gpo_en),
      .intr_gpio_o   (intr_gpio),
      .intr_o        (intr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Reference register state
   logic [31:0] m_out = '0, m_oe = '0, m_state = '0, m_en = '0;
   logic [31:0] m_rise = '0, m_fall = '0, m_stable = '0;
   logic [15:0] m_dbnc = '0;
   logic [31:0] pend_w1c = '0, pend_test = '0;
   logic        pend_dbnc = 1'b0;
   logic [31:0] hist[$];
   int          edge_n = 0;
   int          last_dbnc_wr = -1;
   logic [31:0] last_rd;

   function automatic logic [31:0] sample(int k);
      return (k < 0) ? 32'h0 : hist[k];
   endfunction

   // A pin flips stable once its synchronised value has differed from stable
   // for max(limit,1) consecutive edges since the last DBNC_LIMIT write.
   always @(posedge clk) begin
      if (rst_n) begin : model
         int          lim;
         logic [31:0] ev, v;
         logic        s, run;
         hist.push_back(pins);
         if (pend_dbnc) last_dbnc_wr = edge_n;
         lim = (m_dbnc == 16'd0) ? 1 : int'(m_dbnc);
         ev = '0;
         if (edge_n - lim + 1 > last_dbnc_wr) begin
            for (int i = 0; i < 32; i++) begin
               v = sample(edge_n - SS);
               s = v[i];
               run = (s != m_stable[i]);
               for (int j = 1; j < lim; j++) begin
                  v = sample(edge_n - SS - j);
                  if (v[i] != s) run = 1'b0;
               end
               ev[i] = run;
            end
         end
         m_state  = (m_state & ~pend_w1c) | (ev & ~m_stable & m_rise) | (ev & m_stable & m_fall) | pend_test;
         m_stable = m_stable ^ ev;
         edge_n++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      chk("intr_gpio", intr_gpio, m_state & m_en);
      chk("intr_o", 32'(intr), 32'(|(m_state & m_en)));
      chk("gpio_o", gpo, m_out);
      chk("gpio_en", gpo_en, m_oe);
   endtask

   task automatic tl_access(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] mask, input logic [1:0] size, input int hold,
                            input string tag);
      logic [3:0]  off;
      logic        mapped, err, is_put, is_get;
      logic [31:0] exp_rd;
      logic [7:0]  src;
      off    = addr[5:2];
      mapped = (off <= 4'd8);
`ifdef GPIO_EXT_MASKED_WRITE_EN
      if (off == 4'd9 || off == 4'd10) mapped = 1'b1;
`endif
      is_get = (op == Get);
      is_put = (op == PutFullData) || (op == PutPartialData);
      err = !mapped || (size != 2'd2) || (op == PutPartialData && mask != 4'hF) || !(is_get || is_put);
      case (off)
         4'd0: exp_rd = m_stable;
         4'd1: exp_rd = m_out;
         4'd2: exp_rd = m_oe;
         4'd3: exp_rd = m_state;
         4'd4: exp_rd = m_en;
         4'd5: exp_rd = m_rise;
         4'd6: exp_rd = m_fall;
         4'd7: exp_rd = 32'(m_dbnc);
         default: exp_rd = '0;
      endcase
      if (err || !is_get) exp_rd = '0;
      src = 8'($urandom());
      chk({tag, " a_ready idle"}, 32'(tl_o.a_ready), 32'd1);
      tl_i.a_valid   = 1'b1;
      tl_i.a_opcode  = op;
      tl_i.a_address = addr;
      tl_i.a_data    = data;
      tl_i.a_mask    = mask;
      tl_i.a_size    = size;
      tl_i.a_source  = src;
      tl_i.d_ready   = (hold == 0);
      if (is_put && !err) begin
         case (off)
            4'd1: m_out = data;
            4'd2: m_oe = data;
            4'd3: pend_w1c = data;
            4'd4: m_en = data;
            4'd7: pend_dbnc = 1'b1;
            4'd8: pend_test = data;
            4'd9: m_out[15:0] = (m_out[15:0] & ~data[31:16]) | (data[15:0] & data[31:16]);
            4'd10: m_out[31:16] = (m_out[31:16] & ~data[31:16]) | (data[15:0] & data[31:16]);
            default: ;
         endcase
      end
      step();
      tl_i.a_valid = 1'b0;
      pend_w1c = '0;
      pend_test = '0;
      pend_dbnc = 1'b0;
      if (is_put && !err) begin
         if (off == 4'd5) m_rise = data;
         if (off == 4'd6) m_fall = data;
         if (off == 4'd7) m_dbnc = data[15:0];
      end
      chk({tag, " d_valid"}, 32'(tl_o.d_valid), 32'd1);
      chk({tag, " d_error"}, 32'(tl_o.d_error), 32'(err));
      chk({tag, " d_data"}, tl_o.d_data, exp_rd);
      chk({tag, " d_source"}, 32'(tl_o.d_source), 32'(src));
      chk({tag, " d_size"}, 32'(tl_o.d_size), 32'(size));
      chk({tag, " data_intg"}, 32'(tl_o.d_user.data_intg),
          32'({^exp_rd[31:24], ^exp_rd[23:16], ^exp_rd[15:8], ^exp_rd[7:0]}));
      if (is_get || is_put)
         chk({tag, " d_opcode"}, 32'(tl_o.d_opcode), 32'(is_get ? AccessAckData : AccessAck));
      last_rd = tl_o.d_data;
      for (int h = 0; h < hold; h++) begin
         step();
         chk({tag, " hold a_ready"}, 32'(tl_o.a_ready), 32'd0);
         chk({tag, " hold d_valid"}, 32'(tl_o.d_valid), 32'd1);
         chk({tag, " hold d_data"}, tl_o.d_data, exp_rd);
      end
      tl_i.d_ready = 1'b1;
      step();
      chk({tag, " d_valid drop"}, 32'(tl_o.d_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] a, d;
      logic [3:0]  off;
      int          kind;
      tl_i = '0;
      tl_i.d_ready = 1'b1;
      pins = '0;
      repeat (3) @(negedge clk);
      chk("rst d_valid", 32'(tl_o.d_valid), 32'd0);
      chk("rst a_ready", 32'(tl_o.a_ready), 32'd1);
      chk("rst gpio_o", gpo, 32'd0);
      chk("rst gpio_en", gpo_en, 32'd0);
      chk("rst intr_o", 32'(intr), 32'd0);
      rst_n = 1'b1;
      step();

      tl_access(Get, 32'h04, 0, 4'hF, 2'd2, 0, "rd out rst");
      tl_access(Get, 32'h08, 0, 4'hF, 2'd2, 0, "rd oe rst");
      tl_access(Get, 32'h0C, 0, 4'hF, 2'd2, 0, "rd state rst");

      tl_access(PutFullData, 32'h04, 32'hA5A5_A5A5, 4'hF, 2'd2, 0, "wr out");
      tl_access(PutFullData, 32'h08, 32'hFFFF_0000, 4'hF, 2'd2, 0, "wr oe");
      chk("gpio_o a5", gpo, 32'hA5A5_A5A5);
      chk("gpio_en ffff0000", gpo_en, 32'hFFFF_0000);
      tl_access(Get, 32'h04, 0, 4'hF, 2'd2, 0, "rd out");
      chk("rd out value", last_rd, 32'hA5A5_A5A5);

      // Debounce: short glitch rejected, held level accepted after 2+8 cycles
      tl_access(PutFullData, 32'h1C, 32'd8, 4'hF, 2'd2, 0, "wr dbnc");
      tl_access(PutFullData, 32'h14, 32'h8, 4'hF, 2'd2, 0, "wr rise");
      tl_access(PutFullData, 32'h10, 32'h8, 4'hF, 2'd2, 0, "wr en");
      pins[3] = 1'b1;
      repeat (5) step();
      pins[3] = 1'b0;
      repeat (12) step();
      chk("glitch intr", 32'(intr_gpio[3]), 32'd0);
      tl_access(Get, 32'h00, 0, 4'hF, 2'd2, 0, "rd in glitch");
      chk("glitch data_in", last_rd, 32'd0);
      pins[3] = 1'b1;
      repeat (9) step();
      chk("latency 9", 32'(intr_gpio[3]), 32'd0);
      step();
      chk("latency 10", 32'(intr_gpio[3]), 32'd1);
      tl_access(Get, 32'h00, 0, 4'hF, 2'd2, 0, "rd in high");
      chk("data_in high", last_rd, 32'h8);

      // W1C landing on the same edge as a debounced falling event
      tl_access(PutFullData, 32'h18, 32'h8, 4'hF, 2'd2, 0, "wr fall");
      pins[3] = 1'b0;
      repeat (9) step();
      tl_access(PutFullData, 32'h0C, 32'h8, 4'hF, 2'd2, 0, "w1c collide");
      chk("set beats clear", 32'(intr_gpio[3]), 32'd1);
      tl_access(PutFullData, 32'h0C, 32'h8, 4'hF, 2'd2, 0, "w1c");
      chk("intr_o cleared", 32'(intr), 32'd0);

      // Error responses and back-pressure
      tl_access(Get, 32'h3C, 0, 4'hF, 2'd2, 0, "err unmapped");
      tl_access(PutPartialData, 32'h04, 32'h0, 4'h3, 2'd2, 0, "err partial");
      tl_access(Get, 32'h04, 0, 4'hF, 2'd1, 0, "err size");
      tl_access(3'h2, 32'h04, 32'h0, 4'hF, 2'd2, 0, "err opcode");
      chk("out after errors", gpo, 32'hA5A5_A5A5);
      tl_access(Get, 32'h04, 0, 4'hF, 2'd2, 4, "hold");

      tl_access(PutFullData, 32'h04, 32'h0, 4'hF, 2'd2, 0, "clr out");
      tl_access(PutFullData, 32'h24, 32'h00F0_00FF, 4'hF, 2'd2, 0, "masked lower");
`ifdef GPIO_EXT_MASKED_WRITE_EN
      chk("masked result", gpo, 32'h0000_00F0);
`else
      chk("masked result", gpo, 32'h0);
`endif

      for (int it = 0; it < 200; it++) begin
         kind = int'($urandom_range(0, 3));
         a = $urandom();
         d = $urandom();
         case (kind)
            0: begin
               pins = $urandom();
               repeat ($urandom_range(1, 12)) step();
            end
            1: begin
               off = 4'($urandom_range(1, 10));
               if (off == 4'd7) d = $urandom_range(0, 6);
               a[5:0] = {off, 2'b00};
               tl_access($urandom_range(0, 1) == 0 ? PutFullData : PutPartialData, a, d, 4'hF, 2'd2, 0, "rnd wr");
            end
            2: begin
               off = 4'($urandom_range(0, 10));
               a[5:0] = {off, 2'b00};
               tl_access(Get, a, d, 4'hF, 2'd2, 0, "rnd rd");
            end
            default: begin
               off = 4'($urandom_range(0, 15));
               a[5:0] = {off, 2'b00};
               tl_access(3'($urandom()), a, d, 4'($urandom()), 2'($urandom()), 0, "rnd any");
            end
         endcase
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
